// File: rtl/aoi_cone_pipe.sv
// aoi_cone_pipe: per-lane AOI322 / OAI322 evaluation followed by an elastic
// valid/ready pipeline of DEPTH stages, with a saturating count of the
// 1-bits delivered on the output.
// The gate result is computed ahead of stage 1. Later stages only move
// result, mode and valid forward. Backpressure ripples combinationally from
// out_ready toward in_ready, so a full pipeline still accepts a word on a
// cycle when the output drains.
module aoi_cone_pipe #(
  parameter int LANES = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [LANES-1:0] in_a1,
  input  logic [LANES-1:0] in_a2,
  input  logic [LANES-1:0] in_a3,
  input  logic [LANES-1:0] in_b1,
  input  logic [LANES-1:0] in_b2,
  input  logic [LANES-1:0] in_c1,
  input  logic [LANES-1:0] in_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_y,
  output logic             out_mode,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             cnt_sat
);

  // Popcount width, and a sum width wide enough that counter + popcount
  // cannot wrap before the saturation compare.
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // Mode 0 is the AOI322 function and mode 1 is the OAI322 function.
  function automatic logic [LANES-1:0] cone_eval(
    input logic             mode,
    input logic [LANES-1:0] a1,
    input logic [LANES-1:0] a2,
    input logic [LANES-1:0] a3,
    input logic [LANES-1:0] b1,
    input logic [LANES-1:0] b2,
    input logic [LANES-1:0] c1,
    input logic [LANES-1:0] c2
  );
    logic [LANES-1:0] y;
    if (mode == 1'b0) begin
      y = ~((a1 & a2 & a3) | (b1 & b2) | (c1 & c2));
    end else begin
      y = ~((a1 | a2 | a3) & (b1 | b2) & (c1 | c2));
    end
    return y;
  endfunction

  // Returns the number of set bits in a result word.
  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][LANES-1:0] y_q, y_d;
  logic [DEPTH-1:0]            m_q, m_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        sat_q, sat_d;

  logic [DEPTH:0]              load_s;   // load_s[DEPTH] stands for the downstream sink
  logic [DEPTH-1:0]            adv_s;
  logic [LANES-1:0]            gate_s;
  logic [SUM_W-1:0]            sum_s;
  logic                        out_hs_s;

  // Gate evaluation on the raw operands, ahead of stage 1.
  always_comb begin
    gate_s = cone_eval(in_mode, in_a1, in_a2, in_a3, in_b1, in_b2, in_c1, in_c2);
  end

  // Backpressure chain: a stage advances when it is valid and the stage ahead loads.
  always_comb begin
    adv_s          = '0;
    load_s         = '0;
    load_s[DEPTH]  = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv_s[k]  = v_q[k] & load_s[k+1];
      load_s[k] = ~v_q[k] | adv_s[k];
    end
  end

  // Next-state of the stages. Payload is only written when a valid word moves
  // in, so a stalled output and bubbles leave the data untouched.
  always_comb begin
    v_d = v_q;
    y_d = y_q;
    m_d = m_q;
    if (load_s[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        y_d[0] = gate_s;
        m_d[0] = in_mode;
      end else begin
        y_d[0] = y_q[0];
        m_d[0] = m_q[0];
      end
    end else begin
      v_d[0] = v_q[0];
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (load_s[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          y_d[k] = y_q[k-1];
          m_d[k] = m_q[k-1];
        end else begin
          y_d[k] = y_q[k];
          m_d[k] = m_q[k];
        end
      end else begin
        v_d[k] = v_q[k];
      end
    end
  end

  // Ones counter. A clear takes priority over a handshake in the same cycle.
  // The sticky flag records any addition that was clipped at the maximum.
  always_comb begin
    out_hs_s = v_q[DEPTH-1] & out_ready;
    sum_s    = SUM_W'(cnt_q) + SUM_W'(popcount(y_q[DEPTH-1]));
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (out_hs_s) begin
      if (sum_s > CNT_MAX) begin
        cnt_d = {CNT_W{1'b1}};
        sat_d = 1'b1;
      end else begin
        cnt_d = sum_s[CNT_W-1:0];
        sat_d = sat_q;
      end
    end else begin
      cnt_d = cnt_q;
      sat_d = sat_q;
    end
  end

  // State registers. Reset drops every word in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      y_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      y_q   <= y_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_y     = y_q[DEPTH-1];
  assign out_mode  = m_q[DEPTH-1];
  assign ones_cnt  = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_aoi_cone_pipe.sv
// Bench for aoi_cone_pipe. Four instances share the upstream inputs:
// 0 = DEPTH 2 / CNT_W 16, 1 = DEPTH 1, 2 = DEPTH 4, 3 = DEPTH 2 / CNT_W 4.
// Instance 3 uses the same out_ready as instance 0.
// The reference model treats each instance as a FIFO of accepted words. A
// word becomes visible at max(accept + DEPTH, previous departure + 1).
// in_ready is expected whenever occupancy < DEPTH or the output drains.
module tb_aoi_cone_pipe;
  localparam int NI = 4;
  localparam int DEP  [NI] = '{2, 1, 4, 2};
  localparam int CMAX [NI] = '{65535, 65535, 65535, 15};

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_mode, cnt_clr;
  logic [7:0] a1, a2, a3, b1, b2, c1, c2;
  logic       ordy [NI];
  logic       irdy [NI];
  logic       ov   [NI];
  logic       om   [NI];
  logic       sat  [NI];
  logic [7:0] oy   [NI];
  logic [15:0] cnt [NI];
  logic [3:0] cnt4;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int         cyc;
  int         head [NI];
  int         tail [NI];
  int         last_dep [NI];
  int         mcnt [NI];
  bit         msat [NI];
  logic [7:0] qy   [NI][64];
  bit         qm   [NI][64];
  int         qacc [NI][64];

  // directed burst words
  logic [7:0] wo [4][7];
  bit         wmode [4];

  assign cnt[3] = {12'd0, cnt4};

  always #5 clk = ~clk;

  aoi_cone_pipe #(.LANES(8), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]), .in_mode(in_mode),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .in_b1(b1), .in_b2(b2), .in_c1(c1), .in_c2(c2),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_y(oy[0]), .out_mode(om[0]),
    .cnt_clr(cnt_clr), .ones_cnt(cnt[0]), .cnt_sat(sat[0]));

  aoi_cone_pipe #(.LANES(8), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]), .in_mode(in_mode),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .in_b1(b1), .in_b2(b2), .in_c1(c1), .in_c2(c2),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_y(oy[1]), .out_mode(om[1]),
    .cnt_clr(cnt_clr), .ones_cnt(cnt[1]), .cnt_sat(sat[1]));

  aoi_cone_pipe #(.LANES(8), .DEPTH(4), .CNT_W(16)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]), .in_mode(in_mode),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .in_b1(b1), .in_b2(b2), .in_c1(c1), .in_c2(c2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_y(oy[2]), .out_mode(om[2]),
    .cnt_clr(cnt_clr), .ones_cnt(cnt[2]), .cnt_sat(sat[2]));

  aoi_cone_pipe #(.LANES(8), .DEPTH(2), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]), .in_mode(in_mode),
    .in_a1(a1), .in_a2(a2), .in_a3(a3), .in_b1(b1), .in_b2(b2), .in_c1(c1), .in_c2(c2),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_y(oy[3]), .out_mode(om[3]),
    .cnt_clr(cnt_clr), .ones_cnt(cnt4), .cnt_sat(sat[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane-by-lane gate reference written from the truth conditions.
  function automatic logic [7:0] ref_y(input bit m, input logic [7:0] x1, input logic [7:0] x2,
                                       input logic [7:0] x3, input logic [7:0] y1, input logic [7:0] y2,
                                       input logic [7:0] z1, input logic [7:0] z2);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int na, nb, nc;
      na = int'(x1[i]) + int'(x2[i]) + int'(x3[i]);
      nb = int'(y1[i]) + int'(y2[i]);
      nc = int'(z1[i]) + int'(z2[i]);
      if (m == 1'b0) r[i] = !(na == 3 || nb == 2 || nc == 2);
      else           r[i] = !(na > 0 && nb > 0 && nc > 0);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      head[i] = 0; tail[i] = 0; last_dep[i] = -100; mcnt[i] = 0; msat[i] = 1'b0;
    end
    cyc = 0;
  endtask

  // One cycle of the model, evaluated at the falling edge.
  task automatic model_step();
    int occ, arr, slot;
    bit eov, eir;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        occ = tail[i] - head[i];
        slot = head[i] % 64;
        eov = 1'b0;
        if (occ > 0) begin
          arr = qacc[i][slot] + DEP[i];
          if (last_dep[i] + 1 > arr) arr = last_dep[i] + 1;
          eov = (cyc >= arr);
        end
        eir = (occ < DEP[i]) || (eov && ordy[i]);
        chk($sformatf("out_valid[%0d]@%0d", i, cyc), ov[i], eov);
        chk($sformatf("in_ready[%0d]@%0d", i, cyc), irdy[i], eir);
        if (eov && ov[i]) begin
          chk($sformatf("out_y[%0d]@%0d", i, cyc), oy[i], qy[i][slot]);
          chk($sformatf("out_mode[%0d]@%0d", i, cyc), om[i], qm[i][slot]);
        end
        chk($sformatf("ones_cnt[%0d]@%0d", i, cyc), cnt[i], mcnt[i]);
        chk($sformatf("cnt_sat[%0d]@%0d", i, cyc), sat[i], msat[i]);
        if (eov && ordy[i]) begin
          if (!cnt_clr) begin
            mcnt[i] = mcnt[i] + $countones(qy[i][slot]);
            if (mcnt[i] > CMAX[i]) begin
              mcnt[i] = CMAX[i];
              msat[i] = 1'b1;
            end
          end
          head[i]++;
          last_dep[i] = cyc;
        end
        if (cnt_clr) begin
          mcnt[i] = 0;
          msat[i] = 1'b0;
        end
        if (in_valid && eir) begin
          qy[i][tail[i] % 64]   = ref_y(in_mode, a1, a2, a3, b1, b2, c1, c2);
          qm[i][tail[i] % 64]   = in_mode;
          qacc[i][tail[i] % 64] = cyc;
          tail[i]++;
        end
      end
      cyc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ordy(input bit r0, input bit r1, input bit r2);
    ordy[0] = r0; ordy[3] = r0; ordy[1] = r1; ordy[2] = r2;
  endtask

  task automatic set_ops(input bit m, input logic [7:0] x1, input logic [7:0] x2, input logic [7:0] x3,
                         input logic [7:0] y1, input logic [7:0] y2, input logic [7:0] z1, input logic [7:0] z2);
    in_mode = m; a1 = x1; a2 = x2; a3 = x3; b1 = y1; b2 = y2; c1 = z1; c2 = z2;
  endtask

  // Present one word to instance 0 until it is accepted.
  task automatic send(input bit m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok = irdy[0];
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  task automatic burst_word(input int w);
    set_ops(wmode[w], wo[w][0], wo[w][1], wo[w][2], wo[w][3], wo[w][4], wo[w][5], wo[w][6]);
  endtask

  initial begin
    int  w;
    bit  acc;
    bit  seen;
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    set_ops(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_ordy(1'b1, 1'b1, 1'b1);
    model_reset();
    repeat (3) tick();
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_out_y", oy[0], 8'h00);
    chk("rst_out_mode", om[0], 1'b0);
    chk("rst_ones_cnt", cnt[0], 16'd0);
    chk("rst_cnt_sat", sat[0], 1'b0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", irdy[0], 1'b1);
    tick();

    // AOI322 directed word
    set_ops(1'b0, 8'hFF, 8'h0F, 8'h03, 8'h00, 8'h00, 8'h30, 8'h10);
    send(1'b0);
    tick();
    chk("aoi_valid", ov[0], 1'b1);
    chk("aoi_y", oy[0], 8'hEC);
    chk("aoi_mode", om[0], 1'b0);
    tick();
    chk("aoi_cnt", cnt[0], 16'd5);

    // OAI322 directed word, same operands
    send(1'b1);
    tick();
    chk("oai_y", oy[0], 8'hFF);
    chk("oai_mode", om[0], 1'b1);
    tick();
    chk("oai_cnt", cnt[0], 16'd13);
    repeat (4) tick();

    // Four back-to-back words against a stalled output
    for (int i = 0; i < 4; i++) begin
      wmode[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 7; j++) wo[i][j] = 8'($urandom);
    end
    set_ordy(1'b0, 1'b0, 1'b0);
    w = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      burst_word(w);
      #1;
      acc = irdy[0];
      tick();
      if (acc) w++;
    end
    chk("stall_accepts", w, 2);
    burst_word(w);
    #1;
    chk("stall_in_ready", irdy[0], 1'b0);
    chk("stall_out_valid", ov[0], 1'b1);
    chk("stall_out_y", oy[0], ref_y(wmode[0], wo[0][0], wo[0][1], wo[0][2], wo[0][3], wo[0][4], wo[0][5], wo[0][6]));
    set_ordy(1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 20 && w < 4; t++) begin
      burst_word(w);
      #1;
      acc = irdy[0];
      tick();
      if (acc) w++;
    end
    in_valid = 1'b0;
    chk("release_accepts", w, 4);
    repeat (8) tick();

    // Saturation on the 4-bit counter, then clear on a handshake cycle
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", cnt[0], 16'd0);
    set_ops(1'b1, 8'hFF, 8'h0F, 8'h03, 8'h00, 8'h00, 8'h30, 8'h10);
    send(1'b1);
    send(1'b1);
    repeat (3) tick();
    chk("sat4_cnt", cnt[3], 16'd15);
    chk("sat4_flag", sat[3], 1'b1);
    chk("wide_cnt", cnt[0], 16'd16);
    chk("wide_flag", sat[0], 1'b0);
    send(1'b1);
    seen = ov[0];
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      seen = ov[0];
    end
    chk("clr_hs_seen", seen, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_hs_cnt4", cnt[3], 16'd0);
    chk("clr_hs_sat4", sat[3], 1'b0);
    chk("clr_hs_cnt", cnt[0], 16'd0);
    repeat (6) tick();

    // Reset with words in flight
    set_ops(1'b0, 8'hFF, 8'h0F, 8'h03, 8'h00, 8'h00, 8'h30, 8'h10);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", ov[0], 1'b1);
    chk("pre_rst_cnt", cnt[0], 16'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov[0], 1'b0);
    chk("mid_rst_cnt", cnt[0], 16'd0);
    chk("mid_rst_y", oy[0], 8'h00);
    chk("mid_rst_valid_d4", ov[2], 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", irdy[0], 1'b1);
    repeat (6) tick();

    // Random valid/ready traffic on every instance
    for (int t = 0; t < 600; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      set_ops(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      set_ordy(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      cnt_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    set_ordy(1'b1, 1'b1, 1'b1);
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aoi_cone_pipe.md
AOI_CONE_PIPE -- requirements
Module: aoi_cone_pipe

Interface
REQ-001 SHALL have parameter LANES, default 8: number of independent bit-lanes evaluated in parallel (1..64).
REQ-002 SHALL have parameter DEPTH, default 2: number of elastic pipeline stages (1..4).
REQ-003 SHALL have parameter CNT_W, default 16: width of the ones counter (4..32).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_ready  output  1  block can accept the upstream word this cycle.
REQ-008 SHALL have port in_mode  input  1  0 = AOI322, 1 = OAI322.
REQ-009 SHALL have ports in_a1, in_a2, in_a3, in_b1, in_b2, in_c1, in_c2  input  LANES each  per-lane gate operands.
REQ-010 SHALL have port out_valid  output  1  result word valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_y  output  LANES  per-lane result.
REQ-013 SHALL have port out_mode  output  1  mode that produced out_y.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of ones_cnt and cnt_sat.
REQ-015 SHALL have port ones_cnt  output  CNT_W  running count of 1-bits delivered on out_y.
REQ-016 SHALL have port cnt_sat  output  1  sticky flag; ones_cnt has saturated.

Function
REQ-017 SHALL compute each lane i, mode 0: y[i] = NOT((a1&a2&a3) | (b1&b2) | (c1&c2)).
REQ-018 SHALL compute each lane i, mode 1: y[i] = NOT((a1|a2|a3) & (b1|b2) & (c1|c2)).
REQ-019 SHALL evaluate the gate function combinationally ahead of stage 1; stages 2..DEPTH SHALL carry result, mode and valid unchanged.
REQ-020 SHALL accept an input word on a cycle with in_valid=1 and in_ready=1.
REQ-021 SHALL deliver a result word on a cycle with out_valid=1 and out_ready=1.
REQ-022 SHALL give each stage k a valid bit v[k]. Stage k loads when v[k]=0 or stage k advances; the last stage advances on output handshake.
REQ-023 SHALL drive in_ready = NOT v[1] OR stage 1 advances (combinational from out_ready through the stage chain; no bubble required).
REQ-024 SHALL have latency, with out_ready held 1, of exactly DEPTH cycles from accept to out_valid; throughput SHALL be one word per cycle.
REQ-025 SHALL hold out_y and out_mode stable while out_valid=1 and out_ready=0.
REQ-026 SHALL lose no words and duplicate no words under any in_valid/out_ready pattern; capacity is exactly DEPTH words.
REQ-027 SHALL, on each output handshake, add popcount(out_y) to ones_cnt, saturating at 2^CNT_W-1.
REQ-028 SHALL set cnt_sat when an addition would exceed the maximum; it stays set until cnt_clr or reset.
REQ-029 SHALL, on cnt_clr=1, set ones_cnt=0 and cnt_sat=0; clear wins over a same-cycle handshake, and that word is not counted.
REQ-030 SHALL leave the pipeline unaffected by cnt_clr.

Reset
REQ-031 SHALL, while rst_n=0, immediately force all v[k]=0, out_valid=0, out_y=0, out_mode=0, ones_cnt=0 and cnt_sat=0.
REQ-032 SHALL discard words in flight when reset asserts mid-operation; nothing is emitted after release until new inputs are accepted.
REQ-033 SHALL drive in_ready=1 on the first cycle after rst_n deasserts.

Verification (LANES=8, DEPTH=2, CNT_W=16 unless stated)
REQ-034 SHALL cover: mode 0, a1=FF a2=0F a3=03 b1=b2=00 c1=30 c2=10, out_ready=1 -> out_y=EC two cycles after accept; ones_cnt=5.
REQ-035 SHALL cover: same operands, mode 1 -> out_y=FF, out_mode=1; ones_cnt increases by 8.
REQ-036 SHALL cover: 4 back-to-back words with out_ready=0 -> exactly 2 accepted, then in_ready=0; out_y held. Release out_ready -> all 4 emitted in order, no gaps, no duplicates.
REQ-037 SHALL cover: CNT_W=4, 2 words with out_y=FF -> ones_cnt=15 and cnt_sat=1; cnt_clr on a handshake cycle -> ones_cnt=0 and cnt_sat=0.
REQ-038 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 at once and ones_cnt=0; no stale output after release.
REQ-039 SHALL cover: DEPTH=1 and DEPTH=4 with random valid/ready -> outputs match the scoreboard model, and latency equals DEPTH.
